// File: rtl/popcount_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : popcount_scheduler
// Description : Two-requester round-robin popcount engine built around a single
//               4-bit ones-counter that walks the accepted word a nibble per cycle.
// Revision    : 1.0
// ============================================================================
module popcount_scheduler #(
    parameter int WORD_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req0_valid,
    input  logic [WORD_W-1:0]            req0_data,
    output logic                         req0_ready,
    input  logic                         req1_valid,
    input  logic [WORD_W-1:0]            req1_data,
    output logic                         req1_ready,
    output logic                         res_valid,
    output logic [$clog2(WORD_W+1)-1:0]  res_count,
    output logic                         res_id,
    input  logic                         res_ready,
    output logic                         busy
);

    localparam int NIB   = WORD_W / 4;
    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [WORD_W-1:0] r_word;
    logic [CNT_W-1:0]  r_acc;
    logic [IDX_W-1:0]  r_idx;
    logic              r_last_grant;
    logic              r_res_valid;
    logic [CNT_W-1:0]  r_res_count;
    logic              r_res_id;

    logic              w_idle;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_take;
    logic              w_last;
    logic [3:0]        w_nib;
    logic [2:0]        w_ones;
    logic [CNT_W-1:0]  w_sum;

    // Ties go to the requester that did not win last time.
    assign w_idle     = (r_state == S_IDLE);
    assign w_gnt0     = req0_valid & (~req1_valid | r_last_grant);
    assign w_gnt1     = req1_valid & (~req0_valid | ~r_last_grant);
    assign req0_ready = w_idle & ~rst & w_gnt0;
    assign req1_ready = w_idle & ~rst & w_gnt1;
    assign w_take     = req0_ready | req1_ready;

    // The one shared nibble ones-counter.
    assign w_nib  = r_word[{r_idx, 2'b00} +: 4];
    assign w_ones = 3'(w_nib[0]) + 3'(w_nib[1]) + 3'(w_nib[2]) + 3'(w_nib[3]);
    assign w_sum  = r_acc + CNT_W'(w_ones);
    assign w_last = (r_idx == IDX_W'(NIB - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_take)    w_state_nxt = S_COUNT;
            S_COUNT: if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (res_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word       <= '0;
            r_acc        <= '0;
            r_idx        <= '0;
            r_last_grant <= 1'b1;
            r_res_valid  <= 1'b0;
            r_res_count  <= '0;
            r_res_id     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_word       <= req1_ready ? req1_data : req0_data;
                        r_res_id     <= req1_ready;
                        r_last_grant <= req1_ready;
                        r_acc        <= '0;
                        r_idx        <= '0;
                    end
                end
                S_COUNT: begin
                    r_acc <= w_sum;
                    r_idx <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_res_valid <= 1'b1;
                        r_res_count <= w_sum;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_count = r_res_count;
    assign res_id    = r_res_id;
    assign busy      = ~w_idle;

endmodule
`default_nettype wire
